dram_wr_arbiter: RTL

//  Shares one DRAM write port (data FIFO push + burst-command push) between two

---
 rtl/dram_wr_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/dram_wr_arbiter.sv
// dram_wr_arbiter: round-robin sharing of one DRAM write port between two burst requesters
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   reqN_valid/reqN_cmd/reqN_ack      burst command {len, addr}, ack pulse on completion or reject
//   reqN_wdata/reqN_wvalid/reqN_wready burst data words {strb, data}
//   wr_full                           downstream data FIFO full
//   data_in/data_we                   data FIFO push (registered, one cycle after handshake)
//   ctrl_in/ctrl_we                   command FIFO push, one cycle after the last data push
//   cmd_err                           pulses with ack when the granted length was illegal
//   grant                             one-hot current owner, 0 when idle
module dram_wr_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int MAX_BURST  = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req0_valid,
    input  logic [LEN_WIDTH+ADDR_WIDTH-1:0] req0_cmd,
    output logic                            req0_ack,
    input  logic [35:0]                     req0_wdata,
    input  logic                            req0_wvalid,
    output logic                            req0_wready,
    input  logic                            req1_valid,
    input  logic [LEN_WIDTH+ADDR_WIDTH-1:0] req1_cmd,
    output logic                            req1_ack,
    input  logic [35:0]                     req1_wdata,
    input  logic                            req1_wvalid,
    output logic                            req1_wready,
    input  logic                            wr_full,
    output logic [35:0]                     data_in,
    output logic                            data_we,
    output logic [LEN_WIDTH+ADDR_WIDTH-1:0] ctrl_in,
    output logic                            ctrl_we,
    output logic                            cmd_err,
    output logic [1:0]                      grant
);
    localparam int CW = LEN_WIDTH + ADDR_WIDTH;
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_CTRL} state_t;
    state_t                state_q, state_d;
    logic [1:0]            grant_q, grant_d, ack_q, ack_d;
    logic                  ptr_q, ptr_d, len_ok_q, len_ok_d, err_q, err_d;
    logic                  data_we_q, data_we_d, ctrl_we_q, ctrl_we_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH:0]    cnt_q, cnt_d;
    logic [35:0]           data_q, data_d;
    logic                  pick1, hs, last;
    logic [CW-1:0]         cmd_sel;
    logic [LEN_WIDTH-1:0]  len_in;
    // ptr_q=1 means req1 wins a tie
    assign pick1       = req1_valid && (!req0_valid || ptr_q);
    assign cmd_sel     = pick1 ? req1_cmd : req0_cmd;
    assign len_in      = cmd_sel[CW-1:ADDR_WIDTH];
    assign req0_wready = state_q == S_DATA && len_ok_q && grant_q[0] && !wr_full;
    assign req1_wready = state_q == S_DATA && len_ok_q && grant_q[1] && !wr_full;
    assign hs          = (req0_wready && req0_wvalid) || (req1_wready && req1_wvalid);
    assign last        = cnt_q + (LEN_WIDTH+1)'(1) == {1'b0, len_q};
    assign req0_ack    = ack_q[0];
    assign req1_ack    = ack_q[1];
    assign cmd_err     = err_q;
    assign data_in     = data_q;
    assign data_we     = data_we_q;
    assign ctrl_in     = {len_q, addr_q};
    assign ctrl_we     = ctrl_we_q;
    assign grant       = grant_q;
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        len_d     = len_q;
        addr_d    = addr_q;
        len_ok_d  = len_ok_q;
        cnt_d     = cnt_q;
        ack_d     = '0;
        err_d     = 1'b0;
        ctrl_we_d = 1'b0;
        data_we_d = hs;
        data_d    = hs ? (grant_q[1] ? req1_wdata : req0_wdata) : data_q;
        unique case (state_q)
            S_IDLE: begin
                // the ack cycle is skipped so the acked requester can drop valid first
                if ((req0_valid || req1_valid) && ack_q == '0) begin
                    state_d  = S_DATA;
                    grant_d  = pick1 ? 2'b10 : 2'b01;
                    len_d    = len_in;
                    addr_d   = cmd_sel[ADDR_WIDTH-1:0];
                    len_ok_d = len_in != '0 && int'(len_in) <= MAX_BURST;
                    cnt_d    = '0;
                end
            end
            S_DATA: begin
                if (!len_ok_q) begin
                    state_d = S_IDLE;
                    ack_d   = grant_q;
                    err_d   = 1'b1;
                    grant_d = '0;
                    ptr_d   = grant_q[0];
                end else if (hs) begin
                    cnt_d   = cnt_q + (LEN_WIDTH+1)'(1);
                    state_d = last ? S_CTRL : S_DATA;
                end
            end
            S_CTRL: begin
                state_d   = S_IDLE;
                ack_d     = grant_q;
                ctrl_we_d = 1'b1;
                grant_d   = '0;
                ptr_d     = grant_q[0];
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            ptr_q     <= 1'b0;
            len_q     <= '0;
            addr_q    <= '0;
            len_ok_q  <= 1'b0;
            cnt_q     <= '0;
            ack_q     <= '0;
            err_q     <= 1'b0;
            ctrl_we_q <= 1'b0;
            data_we_q <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            len_ok_q  <= len_ok_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            ctrl_we_q <= ctrl_we_d;
            data_we_q <= data_we_d;
            data_q    <= data_d;
        end
    end
endmodule
